// File: rtl/iddmm_pkg.sv
// Shared FSM encoding and counter-width helpers for the IDDMM job scheduler.
package iddmm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_START = 2'd2;
  localparam state_t ST_RUN   = 2'd3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter addresses groups 0..n-1.
  function automatic int beat_w(input int n);
    return cnt_w(n);
  endfunction

  // Watchdog counter must be able to hold values up to tmo.
  function automatic int wdog_w(input int tmo);
    return cnt_w(tmo + 1);
  endfunction

endpackage

// File: rtl/iddmm_sched_if.sv
// Requester, configuration and multiplier-side signals of the IDDMM scheduler.
interface iddmm_sched_if
  import iddmm_pkg::*;
#(
  parameter int K = 256,
  parameter int N = 16,
  parameter int R = 4
);
  localparam int AW = beat_w(N);

  logic [R-1:0]  req;
  logic [R-1:0]  grant;
  logic          ld_valid;
  logic          ld_ready;
  logic [K-1:0]  ld_x;
  logic [K-1:0]  ld_y;
  logic [K-1:0]  ld_m;
  logic          res_valid;
  logic [K-1:0]  res_data;
  logic          res_last;
  logic          res_err;
  logic          cfg_wr;
  logic [K-1:0]  cfg_m1;
  logic [2:0]    mm_wr_ena;
  logic [AW-1:0] mm_wr_addr;
  logic [K-1:0]  mm_wr_x;
  logic [K-1:0]  mm_wr_y;
  logic [K-1:0]  mm_wr_m;
  logic [K-1:0]  mm_wr_m1;
  logic          mm_task_req;
  logic          mm_task_grant;
  logic [K-1:0]  mm_task_res;
  logic          mm_task_end;

  modport master (
    input  req, ld_valid, ld_x, ld_y, ld_m, cfg_wr, cfg_m1,
           mm_task_grant, mm_task_res, mm_task_end,
    output grant, ld_ready, res_valid, res_data, res_last, res_err,
           mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, mm_task_req
  );

  modport slave (
    output req, ld_valid, ld_x, ld_y, ld_m, cfg_wr, cfg_m1,
           mm_task_grant, mm_task_res, mm_task_end,
    input  grant, ld_ready, res_valid, res_data, res_last, res_err,
           mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, mm_task_req
  );

endinterface

// File: rtl/iddmm_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from the requester after ptr.
module rr_arbiter
  import iddmm_pkg::*;
#(
  parameter int R  = 4,
  parameter int PW = cnt_w(R)
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [R-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= R; i++) begin
      idx = PW'((int'(ptr) + i) % R);
      if (!gnt_vld && req[idx]) begin
        gnt_vld  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/iddmm_sched.sv
// Arbitrates requesters onto one Montgomery multiplier: loads operand groups,
// starts the job, forwards result groups (1-cycle registered) and aborts on watchdog expiry.
module iddmm_sched
  import iddmm_pkg::*;
#(
  parameter int K   = 256,
  parameter int N   = 16,
  parameter int R   = 4,
  parameter int TMO = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  iddmm_sched_if.master bus
);

  localparam int BW = beat_w(N);
  localparam int WW = wdog_w(TMO);
  localparam int PW = cnt_w(R);

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] own_q, own_d;
  logic [R-1:0]  grant_q, grant_d;
  logic [K-1:0]  m1_q, m1_d;
  logic [K-1:0]  res_data_q, res_data_d;
  logic          res_valid_q, res_valid_d;
  logic          res_last_q, res_last_d;
  logic          res_err_q, res_err_d;

  logic [R-1:0]  arb_gnt;
  logic [PW-1:0] arb_idx;
  logic          arb_vld;
  logic          ld_fire;
  logic          wdog_hit;

  rr_arbiter #(.R(R), .PW(PW)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign ld_fire  = (state_q == ST_LOAD) && bus.ld_valid;
  assign wdog_hit = (wdog_q == WW'(TMO - 1));

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wdog_d      = wdog_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    grant_d     = grant_q;
    m1_d        = m1_q;
    res_valid_d = 1'b0;
    res_last_d  = 1'b0;
    res_err_d   = 1'b0;
    res_data_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_wr) m1_d = bus.cfg_m1;
        // The first IDLE cycle still shows the finished job's grant; arbitrate only once it is gone.
        if (grant_q != '0) begin
          grant_d = '0;
        end else if (arb_vld) begin
          grant_d = arb_gnt;
          own_d   = arb_idx;
          beat_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_fire) begin
          if (beat_q == BW'(N - 1)) begin
            beat_d  = '0;
            state_d = ST_START;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.mm_task_grant) begin
          res_valid_d = 1'b1;
          res_data_d  = bus.mm_task_res;
        end
        if (bus.mm_task_end) begin
          res_valid_d = 1'b1;
          res_last_d  = 1'b1;
          wdog_d      = '0;
          ptr_d       = own_q;
          state_d     = ST_IDLE;
        end else if (wdog_hit) begin
          res_valid_d = 1'b1;
          res_last_d  = 1'b1;
          res_err_d   = 1'b1;
          res_data_d  = '0;
          wdog_d      = '0;
          ptr_d       = own_q;
          state_d     = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      wdog_q      <= '0;
      ptr_q       <= PW'(R - 1);
      own_q       <= '0;
      grant_q     <= '0;
      m1_q        <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wdog_q      <= wdog_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      grant_q     <= grant_d;
      m1_q        <= m1_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_err_q   <= res_err_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.ld_ready    = (state_q == ST_LOAD);
  assign bus.mm_wr_ena   = {3{ld_fire}};
  assign bus.mm_wr_addr  = beat_q;
  assign bus.mm_wr_x     = ld_fire ? bus.ld_x : '0;
  assign bus.mm_wr_y     = ld_fire ? bus.ld_y : '0;
  assign bus.mm_wr_m     = ld_fire ? bus.ld_m : '0;
  assign bus.mm_wr_m1    = m1_q;
  assign bus.mm_task_req = (state_q == ST_START);
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_last    = res_last_q;
  assign bus.res_err     = res_err_q;

endmodule

// File: tb/tb_iddmm_sched.sv
// Bench for iddmm_sched: table of jobs driven through a mock multiplier, results scoreboarded.
module tb_iddmm_sched;

  localparam int K   = 16;
  localparam int N   = 4;
  localparam int R   = 4;
  localparam int TMO = 100;

  typedef struct packed {
    logic [K-1:0] data;
    logic         last;
    logic         err;
  } res_t;

  typedef struct {
    logic [R-1:0] req;
    logic [R-1:0] exp_g;
    bit           gappy;
    int           mode;     // 0: end with last beat, 1: end alone, 2: never ends
    bit           drop;
    bit           hold;
    bit           cfg_run;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   treq_cnt = 0;
  int   cur_seed = 0;
  logic [K-1:0] m1_exp;
  res_t sbq[$];
  vec_t tbl[8];

  iddmm_sched_if #(.K(K), .N(N), .R(R)) bus ();

  iddmm_sched #(.K(K), .N(N), .R(R), .TMO(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [K-1:0] px(input int s, input int j);
    return (s == 0) ? K'(1) : K'(s * 256 + j * 4 + 2);
  endfunction
  function automatic logic [K-1:0] py(input int s, input int j);
    return (s == 0) ? K'(1) : K'(s * 256 + j * 4 + 3);
  endfunction
  function automatic logic [K-1:0] pm(input int s, input int j);
    return K'(s * 512 + j * 2 + 1);
  endfunction
  function automatic logic [K-1:0] pr(input int s, input int b);
    return K'(32'hC000 + s * 16 + b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_grant"},     32'(bus.grant), 0);
    chk({name, "_ld_ready"},  32'(bus.ld_ready), 0);
    chk({name, "_wr_ena"},    32'(bus.mm_wr_ena), 0);
    chk({name, "_wr_addr"},   32'(bus.mm_wr_addr), 0);
    chk({name, "_wr_x"},      32'(bus.mm_wr_x), 0);
    chk({name, "_wr_y"},      32'(bus.mm_wr_y), 0);
    chk({name, "_wr_m"},      32'(bus.mm_wr_m), 0);
    chk({name, "_wr_m1"},     32'(bus.mm_wr_m1), 0);
    chk({name, "_task_req"},  32'(bus.mm_task_req), 0);
    chk({name, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({name, "_res_data"},  32'(bus.res_data), 0);
    chk({name, "_res_last"},  32'(bus.res_last), 0);
    chk({name, "_res_err"},   32'(bus.res_err), 0);
  endtask

  // Write port and result port monitors.
  always @(negedge clk) begin
    res_t e;
    if (bus.mm_wr_ena != 3'b000) begin
      chk("wr_ena",  32'(bus.mm_wr_ena), 32'h7);
      chk("wr_addr", 32'(bus.mm_wr_addr), 32'(wr_cnt));
      chk("wr_x",    32'(bus.mm_wr_x), 32'(px(cur_seed, wr_cnt)));
      chk("wr_y",    32'(bus.mm_wr_y), 32'(py(cur_seed, wr_cnt)));
      chk("wr_m",    32'(bus.mm_wr_m), 32'(pm(cur_seed, wr_cnt)));
      wr_cnt++;
    end
    if (bus.mm_task_req) treq_cnt++;
    if (bus.res_valid) begin
      if (sbq.size() == 0) begin
        chk("res_unexpected_valid", 32'(bus.res_valid), 0);
      end else begin
        e = sbq.pop_front();
        chk("res_data", 32'(bus.res_data), 32'(e.data));
        chk("res_last", 32'(bus.res_last), 32'(e.last));
        chk("res_err",  32'(bus.res_err),  32'(e.err));
      end
    end
  end

  task automatic run_job(input vec_t v, input int seed);
    bit   got;
    int   s_cyc;
    int   exp_lat;
    res_t e;
    cur_seed = seed;
    wr_cnt   = 0;
    treq_cnt = 0;
    @(posedge clk); #1;
    bus.req = v.req;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.grant != '0) got = 1;
    end
    if (!got) begin
      chk("grant_timeout", 32'(bus.grant), 32'(v.exp_g));
      bus.req = '0;
      return;
    end
    chk("grant", 32'(bus.grant), 32'(v.exp_g));
    chk("ld_ready_in_load", 32'(bus.ld_ready), 1);
    if (v.drop) bus.req = '0;
    for (int j = 0; j < N; j++) begin
      if (v.gappy) begin
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
      end
      @(posedge clk); #1;
      bus.ld_valid = 1'b1;
      bus.ld_x = px(seed, j);
      bus.ld_y = py(seed, j);
      bus.ld_m = pm(seed, j);
      if (v.cfg_run && j == 0) begin
        bus.cfg_wr = 1'b1;
        bus.cfg_m1 = 16'h1234;
      end
    end
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("task_req_start", 32'(bus.mm_task_req), 1);
    chk("ld_ready_start", 32'(bus.ld_ready), 0);
    s_cyc = cyc;
    if (v.mode != 2) begin
      for (int b = 0; b < N; b++) begin
        @(posedge clk); #1;
        bus.mm_task_grant = 1'b1;
        bus.mm_task_res   = pr(seed, b);
        bus.mm_task_end   = (v.mode == 0) && (b == N - 1);
        if (b == N - 1) bus.cfg_wr = 1'b0;
        e.data = pr(seed, b);
        e.last = (v.mode == 0) && (b == N - 1);
        e.err  = 1'b0;
        sbq.push_back(e);
      end
      if (v.mode == 1) begin
        @(posedge clk); #1;
        bus.mm_task_grant = 1'b0;
        bus.mm_task_res   = '0;
        bus.mm_task_end   = 1'b1;
        e.data = '0; e.last = 1'b1; e.err = 1'b0;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      bus.mm_task_grant = 1'b0;
      bus.mm_task_res   = '0;
      bus.mm_task_end   = 1'b0;
    end else begin
      e.data = '0; e.last = 1'b1; e.err = 1'b1;
      sbq.push_back(e);
    end
    got = 0;
    for (int t = 0; t < TMO + 20 && !got; t++) begin
      @(negedge clk);
      if (bus.res_last) got = 1;
    end
    if (!got) begin
      chk("res_last_timeout", 32'(bus.res_last), 1);
      sbq.delete();
      bus.req = '0;
      return;
    end
    exp_lat = (v.mode == 0) ? N + 1 : (v.mode == 1) ? N + 2 : TMO + 1;
    chk("res_last_latency", 32'(cyc - s_cyc), 32'(exp_lat));
    chk("grant_at_last", 32'(bus.grant), 32'(v.exp_g));
    if (v.cfg_run) chk("m1_kept_busy", 32'(bus.mm_wr_m1), 32'(m1_exp));
    if (!v.hold) bus.req = '0;
    @(negedge clk);
    chk("grant_drop", 32'(bus.grant), 0);
    chk("sb_empty", 32'(sbq.size()), 0);
    chk("wr_count", 32'(wr_cnt), 32'(N));
    chk("task_req_pulses", 32'(treq_cnt), 1);
  endtask

  initial begin
    vec_t wd;
    bit   got;
    tbl[0] = '{4'b0001, 4'b0001, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b1111, 4'b0010, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{4'b1111, 4'b0100, 1'b0, 1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{4'b1111, 4'b1000, 1'b1, 0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{4'b1111, 4'b0001, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{4'b0100, 4'b0100, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{4'b1001, 4'b1000, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{4'b1001, 4'b0001, 1'b0, 1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.req = '0; bus.ld_valid = 1'b0; bus.ld_x = '0; bus.ld_y = '0; bus.ld_m = '0;
    bus.cfg_wr = 1'b0; bus.cfg_m1 = '0;
    bus.mm_task_grant = 1'b0; bus.mm_task_res = '0; bus.mm_task_end = 1'b0;
    m1_exp = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    // m' loads in IDLE, visible the following cycle.
    @(posedge clk); #1;
    bus.cfg_wr = 1'b1;
    bus.cfg_m1 = 16'hA5A5;
    @(negedge clk);
    chk("m1_before_edge", 32'(bus.mm_wr_m1), 0);
    @(posedge clk); #1;
    bus.cfg_wr = 1'b0;
    @(negedge clk);
    chk("m1_after_edge", 32'(bus.mm_wr_m1), 32'hA5A5);
    m1_exp = 16'hA5A5;

    for (int i = 0; i < 8; i++) run_job(tbl[i], i);

    wd = '{4'b0010, 4'b0010, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    run_job(wd, 8);

    // Reset asserted in the middle of LOAD.
    cur_seed = 10;
    wr_cnt   = 0;
    @(posedge clk); #1;
    bus.req = 4'b0100;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (bus.grant != '0) got = 1;
    end
    chk("rst_job_grant", 32'(bus.grant), 32'b0100);
    bus.req = '0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      bus.ld_valid = 1'b1;
      bus.ld_x = px(10, j);
      bus.ld_y = py(10, j);
      bus.ld_m = pm(10, j);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("mid_load_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.ld_valid = 1'b0;
    m1_exp = '0;
    repeat (2) @(negedge clk);
    chk("rst_no_grant", 32'(bus.grant), 0);

    wd = '{4'b1111, 4'b0001, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    run_job(wd, 11);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/iddmm_sched.md
IDDMM_SCHED -- requirements
Module: iddmm_sched

Interface
REQ-001 SHALL have parameter K, default 256, the bit width of one operand group.
REQ-002 SHALL have parameter N, default 16, the number of groups per operand.
REQ-003 SHALL have parameter R, default 4, the number of requesters.
REQ-004 SHALL have parameter TMO, default 65535, the watchdog limit in cycles for one multiplication.
REQ-005 SHALL have these clock and reset ports; one clock, reset asynchronous and active-low:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
REQ-006 SHALL have these requester-side ports:
- req  in  R  per-requester job request, level
- grant  out  R  one-hot owner of the multiplier
- ld_valid  in  1  operand beat valid, from the owner
- ld_ready  out  1  operand beat accepted
- ld_x  in  K  operand x group
- ld_y  in  K  operand y group
- ld_m  in  K  modulus m group
- res_valid  out  1  result group valid
- res_data  out  K  result group
- res_last  out  1  final result group / job end
- res_err  out  1  job aborted by watchdog, valid with res_last
REQ-007 SHALL have these configuration ports:
- cfg_wr  in  1  load the m' register
- cfg_m1  in  K  m' = -m^-1 mod 2^K
REQ-008 SHALL have these multiplier-side ports:
- mm_wr_ena  out  3  write enables {m,y,x}
- mm_wr_addr  out  $clog2(N)  group address
- mm_wr_x / mm_wr_y / mm_wr_m  out  K  operand groups
- mm_wr_m1  out  K  registered m'
- mm_task_req  out  1  start pulse
- mm_task_grant  in  1  result group valid
- mm_task_res  in  K  result group
- mm_task_end  in  1  multiplication finished

Function
REQ-009 SHALL implement the FSM IDLE -> LOAD -> START -> RUN -> IDLE.
REQ-010 IDLE: when any req bit is set, SHALL pick the winner round-robin, starting at the bit after the last served requester; SHALL assert its grant bit on the next cycle and enter LOAD.
REQ-011 grant SHALL stay constant from LOAD through the res_last cycle and SHALL drop in the cycle after res_last.
REQ-012 LOAD: ld_ready SHALL be 1; on each ld_valid&ld_ready beat, SHALL drive mm_wr_ena=3'b111, mm_wr_addr equal to the beat count, and the ld_* data, all in the same cycle.
REQ-013 LOAD: the beat counter SHALL count 0..N-1; after beat N-1, SHALL enter START. ld_valid gaps SHALL be tolerated.
REQ-014 START: SHALL assert mm_task_req for exactly one cycle, then enter RUN.
REQ-015 RUN: SHALL forward each mm_task_grant beat as res_valid/res_data, registered with 1-cycle latency.
REQ-016 RUN: SHALL assert res_last on the beat coinciding with mm_task_end; if mm_task_end arrives without mm_task_grant, SHALL emit a res_valid beat with res_last=1 and res_data=0. SHALL then return to IDLE.
REQ-017 SHALL run a watchdog counter, starting at 0 in START; if it reaches TMO in RUN, SHALL emit res_valid=1, res_last=1, res_err=1, res_data=0 and return to IDLE.
REQ-018 SHALL update the round-robin pointer to the served requester on return to IDLE, including on watchdog abort.
REQ-019 If the owner's req drops mid-job, SHALL continue the job; requests SHALL be sampled only in IDLE.
REQ-020 cfg_wr SHALL update the m' register only in IDLE; it SHALL be ignored in all other states.
REQ-021 When not loading, mm_wr_ena SHALL be 0; ld_ready SHALL be 0 outside LOAD.
REQ-022 A new arbitration SHALL occur no earlier than the cycle after the return to IDLE, giving at least one idle cycle between jobs.

Reset
REQ-023 On rst_n low, state SHALL be IDLE, all counters 0, the round-robin pointer R-1, and the m' register 0.
REQ-024 On rst_n low, every output SHALL be 0.
REQ-025 Reset mid-job SHALL abort the job without emitting res_last.

Structure
REQ-026 SHALL place the FSM state enum and the beat/watchdog width constants in shared package iddmm_pkg.
REQ-027 SHALL factor round-robin arbitration into sub-module rr_arbiter, parameterized by R.

Verification
REQ-028 Single job: req=4'b0001, N beats with x=y=1, m odd; SHALL show grant=0001, mm_wr_addr 0..N-1, one mm_task_req pulse, and res_last on the beat with mm_task_end.
REQ-029 Contention: req=4'b1111 held; SHALL serve grants in order 0001, 0010, 0100, 1000, 0001.
REQ-030 Gappy load: ld_valid toggling every other cycle; SHALL produce exactly N writes with contiguous addresses.
REQ-031 Watchdog: TMO=100, no mm_task_end; SHALL show res_err=res_last=1 at cycle 100 of RUN, then IDLE.
REQ-032 cfg_wr during RUN SHALL leave mm_wr_m1 unchanged; cfg_wr in IDLE SHALL change mm_wr_m1 on the next cycle.
REQ-033 rst_n pulsed low mid-LOAD; SHALL show all outputs 0 and the next job served from requester 0.
